score_ctrl: RTL and testbench

- Game-level score controller that sequences the active-low seven-segment digit displays.
- Accepts one-cycle `point` pulses and keeps a DIGITS-wide BCD score with a decimal carry chain between digits.
- Runs the IDLE/PLAY/OVER game state machine and drives the segment codes for all score digits.
- Sits between the game FSM (collision and pipe-pass detection) and the board HEX outputs.

---
 rtl/score_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_score_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
//
// Game-level score controller. Keeps a DIGITS-wide BCD score that advances on
// one-cycle point pulses, runs the IDLE/PLAY/OVER game state machine and drives
// active-low seven-segment codes (gfedcba) for every score digit.
//
// Optional feature macro: SCORE_BEST_EN
//   defined   - a BCD best-score register is built; a game that beats it sets
//               new_best, blinks the OVER display, and IDLE shows the best.
//   undefined - no best register; new_best is tied low and IDLE shows the score.
//
// Parameters:
//   DIGITS        number of BCD score digits (1..4)
//   BLINK_CYCLES  cycles per blink half-period while in OVER
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous reset, active-high
//   start     in   one-cycle pulse, begins a game (IDLE/OVER -> PLAY)
//   point     in   one-cycle pulse, adds 1 to the score in PLAY
//   crash     in   one-cycle pulse, ends the game (PLAY -> OVER)
//   seg       out  7*DIGITS active-low segment codes, digit 0 in seg[6:0]
//   state     out  2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER
//   rollover  out  one-cycle pulse when the score wraps from all-9s to 0
//   new_best  out  high in OVER when the finished game set a new best
// -----------------------------------------------------------------------------
module score_ctrl #(
   parameter int unsigned DIGITS       = 3,
   parameter int unsigned BLINK_CYCLES = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  point,
   input  logic                  crash,
   output logic [7*DIGITS-1:0]   seg,
   output logic [1:0]            state,
   output logic                  rollover,
   output logic                  new_best
);

   localparam int unsigned   CntW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StPlay = 2'b01,
      StOver = 2'b10
   } state_e;

   state_e                r_state;
   logic [4*DIGITS-1:0]   r_score;
   logic                  r_rollover;
   logic [CntW-1:0]       r_blink_cnt;
   logic                  r_blink_vis;

   logic [4*DIGITS-1:0]   w_score_inc;
   logic                  w_carry;
   logic [4*DIGITS-1:0]   w_disp;
   logic                  w_blank;
   logic                  w_new_best;

`ifdef SCORE_BEST_EN
   logic [4*DIGITS-1:0]   r_best;
   logic                  r_new_best;
   logic [4*DIGITS-1:0]   w_final;
`endif

   // Active-low gfedcba code for one BCD digit; non-BCD values show blank.
   function automatic logic [6:0] f_seg(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = 7'b1000000;
         4'd1:    code = 7'b1111001;
         4'd2:    code = 7'b0100100;
         4'd3:    code = 7'b0110000;
         4'd4:    code = 7'b0011001;
         4'd5:    code = 7'b0010010;
         4'd6:    code = 7'b0000010;
         4'd7:    code = 7'b1111000;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0010000;
         default: code = 7'b1111111;
      endcase
      return code;
   endfunction

   // Decimal carry chain: a digit advances only while every lower digit is 9.
   // w_carry left set after the last digit means the whole score was all-9s.
   always_comb begin
      w_score_inc = r_score;
      w_carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_carry) begin
            if (r_score[4*i +: 4] == 4'd9) begin
               w_score_inc[4*i +: 4] = 4'd0;
            end else begin
               w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
               w_carry               = 1'b0;
            end
         end
      end
   end

`ifdef SCORE_BEST_EN
   // Score the game ends with, including a point arriving with the crash.
   assign w_final    = point ? w_score_inc : r_score;
   assign w_new_best = r_new_best;
`else
   assign w_new_best = 1'b0;
`endif

   // Game FSM, score, best score and blink timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_score     <= '0;
         r_rollover  <= 1'b0;
         r_blink_cnt <= '0;
         r_blink_vis <= 1'b1;
`ifdef SCORE_BEST_EN
         r_best      <= '0;
         r_new_best  <= 1'b0;
`endif
      end else begin
         r_rollover <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_score <= '0;
                  r_state <= StPlay;
               end
            end

            StPlay: begin
               if (point) begin
                  r_score    <= w_score_inc;
                  r_rollover <= w_carry;
               end
               if (crash) begin
                  r_state     <= StOver;
                  r_blink_cnt <= '0;
                  r_blink_vis <= 1'b1;
`ifdef SCORE_BEST_EN
                  // Packed BCD compares numerically as a plain unsigned vector.
                  if (w_final > r_best) begin
                     r_best     <= w_final;
                     r_new_best <= 1'b1;
                  end
`endif
               end
            end

            StOver: begin
               if (start) begin
                  r_score <= '0;
                  r_state <= StPlay;
`ifdef SCORE_BEST_EN
                  r_new_best <= 1'b0;
`endif
               end else if (r_blink_cnt == CntMax) begin
                  r_blink_cnt <= '0;
                  r_blink_vis <= ~r_blink_vis;
               end else begin
                  r_blink_cnt <= r_blink_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Display source and blanking depend only on registered state.
   always_comb begin
      w_disp = r_score;
`ifdef SCORE_BEST_EN
      if (r_state == StIdle) begin
         w_disp = r_best;
      end
`endif
      w_blank = (r_state == StOver) && w_new_best && !r_blink_vis;
   end

   always_comb begin
      seg = '1;
      for (int i = 0; i < DIGITS; i++) begin
         seg[7*i +: 7] = w_blank ? 7'b1111111 : f_seg(w_disp[4*i +: 4]);
      end
   end

   assign state    = r_state;
   assign rollover = r_rollover;
   assign new_best = w_new_best;

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
//
// Drives score_ctrl with directed game sequences followed by random pulses.
// A behavioural model (integer score/best, cycle count since OVER entry)
// predicts the outputs after every clock edge; predictions are queued with
// the edge number they belong to, and a separate monitor compares them on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

   localparam int unsigned DIGITS       = 3;
   localparam int unsigned BLINK_CYCLES = 4;

`ifdef SCORE_BEST_EN
   localparam bit BestEn = 1'b1;
`else
   localparam bit BestEn = 1'b0;
`endif

   localparam int MStIdle = 0;
   localparam int MStPlay = 1;
   localparam int MStOver = 2;

   logic                clk;
   logic                reset;
   logic                start;
   logic                point;
   logic                crash;
   logic [7*DIGITS-1:0] seg;
   logic [1:0]          state;
   logic                rollover;
   logic                new_best;

   score_ctrl #(
      .DIGITS       (DIGITS),
      .BLINK_CYCLES (BLINK_CYCLES)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .point    (point),
      .crash    (crash),
      .seg      (seg),
      .state    (state),
      .rollover (rollover),
      .new_best (new_best)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int                  cyc;
      logic [1:0]          st;
      logic [7*DIGITS-1:0] seg;
      logic                ro;
      logic                nb;
   } exp_t;

   exp_t q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // Reference model state.
   int   m_state = MStIdle;
   int   m_score = 0;
   int   m_best  = 0;
   bit   m_nb    = 1'b0;
   bit   m_ro    = 1'b0;
   int   m_ovc   = 0;
   int   m_max;

   logic [6:0] seg_tbl [10];

   initial begin
      seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
      seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
      seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
      seg_tbl[9] = 7'b0010000;
      m_max = 1;
      for (int i = 0; i < DIGITS; i++) m_max = m_max * 10;
      m_max = m_max - 1;
   end

   function automatic logic [7*DIGITS-1:0] show(input int val, input bit blank);
      logic [7*DIGITS-1:0] s;
      int v;
      v = val;
      for (int i = 0; i < DIGITS; i++) begin
         s[7*i +: 7] = blank ? 7'b1111111 : seg_tbl[v % 10];
         v = v / 10;
      end
      return s;
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit p, input bit c);
      if (r) begin
         m_state = MStIdle; m_score = 0; m_best = 0; m_nb = 0; m_ro = 0; m_ovc = 0;
      end else begin
         m_ro = 0;
         case (m_state)
            MStIdle: if (s) begin m_score = 0; m_state = MStPlay; end
            MStPlay: begin
               if (p) begin
                  if (m_score == m_max) begin m_score = 0; m_ro = 1; end
                  else m_score = m_score + 1;
               end
               if (c) begin
                  m_state = MStOver;
                  m_ovc   = 0;
                  if (BestEn && m_score > m_best) begin m_best = m_score; m_nb = 1; end
               end
            end
            default: begin
               if (s) begin m_score = 0; m_nb = 0; m_state = MStPlay; end
               else m_ovc = m_ovc + 1;
            end
         endcase
      end
   endtask

   task automatic push_expect();
      exp_t e;
      bit   blank;
      int   val;
      blank = (m_state == MStOver) && m_nb && (((m_ovc / BLINK_CYCLES) % 2) == 1);
      val   = (m_state == MStIdle && BestEn) ? m_best : m_score;
      e.cyc = edge_cnt + 1;
      e.st  = 2'(m_state);
      e.seg = show(val, blank);
      e.ro  = m_ro;
      e.nb  = m_nb;
      q.push_back(e);
   endtask

   // Apply one cycle of inputs, predict the response to the coming edge.
   task automatic step(input bit r, input bit s, input bit p, input bit c);
      reset = r; start = s; point = p; crash = c;
      model_edge(r, s, p, c);
      push_expect();
      @(posedge clk);
      #1;
   endtask

   task automatic points(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   // Monitor: compare DUT outputs with the prediction for the latest edge.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < edge_cnt) begin
         e = q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL stale_entry cyc=%0d never checked (now %0d)", e.cyc, edge_cnt);
      end
      if (q.size() > 0 && q[0].cyc == edge_cnt) begin
         e = q.pop_front();
         vectors++;
         if (state !== e.st || seg !== e.seg || rollover !== e.ro || new_best !== e.nb) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got state=%b seg=%b ro=%b nb=%b exp state=%b seg=%b ro=%b nb=%b",
                     edge_cnt, state, seg, rollover, new_best, e.st, e.seg, e.ro, e.nb);
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; point = 1'b0; crash = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      idle(2);

      // 12 back-to-back points.
      step(0, 1, 0, 0);
      points(12);
      idle(1);

      // Reach 041, then point+crash together; watch the blink.
      points(29);
      step(0, 0, 1, 1);
      idle(10);

      // OVER ignores point/crash, then a new game.
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      idle(1);
      step(0, 1, 0, 0);

      // Game ending below the best: no blink.
      points(17);
      step(0, 0, 0, 1);
      idle(10);

      // Reset back to IDLE clears best.
      step(1, 0, 0, 0);
      idle(3);

      // Rollover at 999 -> 000.
      step(0, 1, 0, 0);
      points(998);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      idle(2);
      step(0, 0, 0, 1);
      idle(10);

      // Random pulses.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 39) == 0));
      end
      idle(2);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending, exp 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
